// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared constants, pointer type and helpers for the FIFO write arbiter
package fifo_arb_pkg;

   // Largest requester count the arbiter is sized for
   localparam int MAX_REQ = 8;

   // Default memory depth used for the shared pointer type
   localparam int DEF_DEPTH = 16;

   // Address width for a power-of-two memory depth
   function automatic int addr_w(input int depth);
      return $clog2(depth);
   endfunction

   localparam int DEF_ADDR_W = addr_w(DEF_DEPTH);

   // Pointer carries one extra wrap bit beyond the address
   typedef logic [DEF_ADDR_W:0] ptr_t;

endpackage

// File: rtl/fifo_wr_arb_ctrl_rr_arbiter.sv
// rtl/fifo_wr_arb_ctrl_rr_arbiter.sv - combinational round-robin arbiter, scan starts after last winner
module rr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int N     = 4,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     i_req,
   input  logic             i_enable,
   input  logic [IDX_W-1:0] i_last,
   output logic [N-1:0]     o_gnt,
   output logic [IDX_W-1:0] o_winner
);

   // Walk indices last+1 .. last+N (mod N); the first asserted request wins
   always_comb begin : p_scan
      logic             v_found;
      logic [IDX_W-1:0] v_idx;
      o_gnt    = '0;
      o_winner = '0;
      v_found  = 1'b0;
      v_idx    = '0;
      for (int k = 1; k <= N; k++) begin
         v_idx = IDX_W'((int'(i_last) + k) % N);
         if (!v_found && i_enable && i_req[v_idx]) begin
            o_gnt[v_idx] = 1'b1;
            o_winner     = v_idx;
            v_found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arb_ctrl.sv
// rtl/fifo_wr_arb_ctrl.sv - shared fifo_mem write-port arbiter with pointers and flags (option: FIFO_ARB_WATERMARK_EN)
module fifo_wr_arb_ctrl
   import fifo_arb_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int DEPTH   = 16,
   parameter int NUM_REQ = 4
`ifdef FIFO_ARB_WATERMARK_EN
   ,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2
`endif
) (
   input  logic                       w_clk,
   input  logic                       w_rst,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]         gnt,
   input  logic                       rd_en,
   output logic                       rd_valid,
   output logic                       wr_rq,
   output logic                       rd_rq,
   output logic [$clog2(DEPTH)-1:0]   waddr,
   output logic [$clog2(DEPTH)-1:0]   raddr,
   output logic [WIDTH-1:0]           wdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
`ifdef FIFO_ARB_WATERMARK_EN
   ,
   output logic                       almost_full,
   output logic                       almost_empty
`endif
);

   localparam int ADDR_W = addr_w(DEPTH);
   localparam int IDX_W  = $clog2(NUM_REQ);

   logic [ADDR_W:0]      r_wr_ptr;
   logic [ADDR_W:0]      r_rd_ptr;
   logic [IDX_W-1:0]     r_last;

   logic [NUM_REQ-1:0]   w_gnt;
   logic [IDX_W-1:0]     w_winner;
   logic                 w_arb_en;
   logic                 w_full;
   logic                 w_empty;

   // Flags come from registered pointers only; no same-cycle write/read feedthrough
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                    (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);

   // Grants are suppressed while full and while reset is asserted
   assign w_arb_en = !w_full && !w_rst;

   rr_arbiter #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_rr_arbiter (
      .i_req    (req),
      .i_enable (w_arb_en),
      .i_last   (r_last),
      .o_gnt    (w_gnt),
      .o_winner (w_winner)
   );

   assign gnt      = w_gnt;
   assign wr_rq    = |w_gnt;
   assign rd_rq    = rd_en;
   assign rd_valid = rd_en && !w_empty;
   assign waddr    = r_wr_ptr[ADDR_W-1:0];
   assign raddr    = r_rd_ptr[ADDR_W-1:0];
   assign full     = w_full;
   assign empty    = w_empty;
   assign count    = r_wr_ptr - r_rd_ptr;

   // Select the granted producer's slice; zero when nobody holds the grant
   always_comb begin
      wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_gnt[i]) begin
            wdata = req_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // Pointer advance and round-robin history; last moves only when a grant is issued
   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_last   <= IDX_W'(NUM_REQ - 1);
      end else begin
         if (wr_rq) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            r_last   <= w_winner;
         end
         if (rd_valid) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

`ifdef FIFO_ARB_WATERMARK_EN
   // Watermarks are decoded from the registered occupancy
   assign almost_full  = (int'(count) >= AF_LEVEL);
   assign almost_empty = (int'(count) <= AE_LEVEL);
`endif

endmodule

// File: doc/fifo_wr_arb_ctrl.md
Name: fifo_wr_arb_ctrl

Overview:
- Single-clock controller that shares one fifo_mem write port among NUM_REQ producers using round-robin arbitration.
- Generates write/read addresses, full/empty flags and occupancy for one consumer.
- Sits between producer logic and the fifo_mem instance; drives its wr_rq, rd_rq, waddr, raddr, wdata, full and empty inputs.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, memory depth; must be a power of two and at least 2.
- NUM_REQ, 4, number of write requesters; range 2..8.

Ports:
- w_clk  in  1  sole clock.
- w_rst  in  1  reset; synchronous, active-high.
- req  in  NUM_REQ  per-producer write request.
- req_data  in  NUM_REQ*WIDTH  packed producer data; slice i is bits [i*WIDTH +: WIDTH].
- gnt  out  NUM_REQ  one-hot grant; a write of slice i occurs at the next edge.
- rd_en  in  1  consumer read request.
- rd_valid  out  1  rd_en && !empty; rdata from fifo_mem is valid this cycle.
- wr_rq  out  1  to fifo_mem; equals |gnt.
- rd_rq  out  1  to fifo_mem; equals rd_en.
- waddr  out  $clog2(DEPTH)  write pointer, low bits.
- raddr  out  $clog2(DEPTH)  read pointer, low bits.
- wdata  out  WIDTH  req_data slice of the granted requester; zero when there is no grant.
- full  out  1  FIFO full.
- empty  out  1  FIFO empty.
- count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH.

Behaviour:
- Interface decision: one clock, w_clk; reset w_rst is synchronous and active-high.
- Pointers:
  - wr_ptr and rd_ptr are registered, ADDR_W+1 bits wide (ADDR_W = $clog2(DEPTH)), and wrap naturally modulo 2*DEPTH.
  - waddr and raddr are the low ADDR_W bits.
- Flags, decoded from the registered pointers only (no same-cycle feedthrough):
  - empty = (wr_ptr == rd_ptr).
  - full = MSBs differ and low bits are equal.
  - count = wr_ptr - rd_ptr, unsigned, ADDR_W+1 bits.
- Arbitration (combinational):
  - If full, gnt = 0.
  - Otherwise scan req starting at index (last+1) mod NUM_REQ upward with wrap; the first set bit wins.
  - last is a registered index that updates to the winner only on a grant cycle and holds otherwise.
  - Requests do not need to be held. A producer whose req drops is simply skipped.
  - A producer must hold req and req_data until it sees gnt.
- Write:
  - On the edge where |gnt is set, fifo_mem stores wdata at waddr and wr_ptr increments by 1.
  - Exactly one write per cycle maximum.
- Read:
  - Asynchronous read datapath: rdata is valid in the same cycle as rd_valid.
  - On the edge where rd_valid is set, rd_ptr increments by 1.
  - rd_en while empty is ignored: no pointer move, rd_valid = 0.
- Simultaneous write and read:
  - Both pointers advance; count is unchanged.
  - When full, the write is blocked and the read proceeds; full deasserts next cycle.
  - When empty, the read is blocked and the write proceeds; data is readable the next cycle (write-to-read latency 1).
- Reset values, applied at the next edge with w_rst = 1, regardless of in-flight traffic:
  - wr_ptr = 0, rd_ptr = 0, last = NUM_REQ-1 (req[0] has first priority).
  - Hence empty = 1, full = 0, count = 0.
  - gnt = 0 and wr_rq = 0 whenever w_rst is high.
  - Memory contents are not cleared.
- Occupancy changes by at most ±1 per cycle; count never exceeds DEPTH.

Optional Feature:
- Macro FIFO_ARB_WATERMARK_EN.
- Defined:
  - Adds parameters AF_LEVEL (default DEPTH-2) and AE_LEVEL (default 2).
  - Adds output ports almost_full = (count >= AF_LEVEL) and almost_empty = (count <= AE_LEVEL).
  - Both are decoded combinationally from registered count.
  - Reset values: almost_full = 0, almost_empty = 1.
- Undefined: neither these ports nor the logic exist; all other behaviour is identical.

Decomposition:
- Package fifo_arb_pkg:
  - function addr_w(depth) returning $clog2(depth).
  - typedef ptr_t, ADDR_W+1 bits.
  - localparam MAX_REQ = 8.
- Sub-module rr_arbiter, parameter N:
  - Inputs: req, enable (= !full), last index.
  - Outputs: one-hot gnt and winner index.
  - Purely combinational; the last register stays in the parent.
- The top instantiates rr_arbiter and the pointer/flag logic, and muxes req_data into wdata.

Test Plan:
- Reset then idle: empty=1, full=0, count=0, gnt=0; rd_en=1 gives rd_valid=0 and raddr stays 0.
- req=4'b1111 held for 4 cycles, no reads: gnt sequence is 0001, 0010, 0100, 1000; count reaches 4; reads return slices 0, 1, 2, 3 in order.
- Fill with a single requester for 16 cycles: full=1 and count=16 after the 16th write; the 17th request gets gnt=0 and waddr holds 0.
- Full and req[2]=1 and rd_en=1 in the same cycle: read occurs, no grant; next cycle full=0, count=15, then gnt=0100 and the write goes to the freed slot.
- Empty, then req[1] and rd_en together: write accepted, rd_valid=0; next cycle rd_valid=1 with rdata equal to the written word and count=1.
- Assert w_rst mid-traffic with count=7: after the next edge count=0, empty=1, gnt=0, and the next grant goes to req[0] when all requests are high. With FIFO_ARB_WATERMARK_EN: after 14 writes almost_full=1; after reset almost_empty=1.
